// File: rtl/mux_pkg.sv
// Shared definitions for the scan multiplexer: mode encoding and the
// rotating first-one search used by the round-robin arbiter.
// Purely declarative; no ports, no state.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Upper bound on channel count the search function handles; callers
  // zero-extend their valid vector to this width.
  localparam int MUX_MAX_CH = 32;
  localparam int MUX_IDX_W  = 5;

  typedef struct packed {
    logic                 found;
    logic [MUX_IDX_W-1:0] idx;
  } rr_res_t;

  // Returns the first set bit of vld[n-1:0] searching ptr, ptr+1, ...,
  // wrapping modulo n. ptr is assumed to be < n.
  function automatic rr_res_t rr_first_one(input int n, input int ptr,
                                           input logic [MUX_MAX_CH-1:0] vld);
    rr_res_t res;
    int      c;
    res = '0;
    for (int k = 0; k < MUX_MAX_CH; k++) begin
      c = ptr + k;
      if (c >= n) c = c - n;
      if (k < n && !res.found && vld[c[MUX_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = c[MUX_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_scan_arb.sv
// Rotating-priority arbiter: picks the first valid channel at or after ptr.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: i_vld (per-channel valid), i_ptr (search start), o_found, o_idx.
module mux_scan_arb
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  i_vld,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_found,
  output logic [SEL_W-1:0] o_idx
);

  logic [MUX_MAX_CH-1:0] w_vld_ext;
  rr_res_t               w_res;
  logic                  w_unused_idx;

  if (N_CH < MUX_MAX_CH) begin : g_pad
    assign w_vld_ext = {{(MUX_MAX_CH-N_CH){1'b0}}, i_vld};
  end else begin : g_nopad
    assign w_vld_ext = i_vld;
  end

  assign w_res        = rr_first_one(N_CH, int'(i_ptr), w_vld_ext);
  assign o_found      = w_res.found;
  assign o_idx        = w_res.idx[SEL_W-1:0];
  // Upper index bits are always zero for legal channel counts.
  assign w_unused_idx = ^w_res.idx;

endmodule

// File: rtl/mux_scan.sv
// N-channel registered mux, manual select or round-robin scan over valid channels.
// Latency: 1 cycle in_valid&&in_ready -> out_valid; full throughput with out_ready=1.
// Backpressure: one-entry output register; in_ready=0 while full and out_ready=0.
// Ports: in_data/in_valid/in_ready per channel; mode (0 manual,1 scan); sel;
//        out_data/out_ch/out_valid/out_ready towards the consumer.
// Optional: MUX_SCAN_PARITY_EN adds out_par = ^out_data (registered).
module mux_scan
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic              out_par
`endif
);

  logic [W-1:0]     w_ch_dat [N_CH];
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [SEL_W-1:0] w_arb_idx;
  logic [SEL_W-1:0] w_cand;
  logic             w_arb_found;
  logic             w_cand_ok;
  logic             w_load;
  logic             w_cap;
  logic             r_out_valid;
  logic [W-1:0]     r_out_data;
  logic [SEL_W-1:0] r_out_ch;

  for (genvar c = 0; c < N_CH; c++) begin : g_unpack
    assign w_ch_dat[c] = in_data[c*W +: W];
  end

  mux_scan_arb #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .i_vld   (in_valid),
    .i_ptr   (r_ptr),
    .o_found (w_arb_found),
    .o_idx   (w_arb_idx)
  );

  always_comb begin
    w_cand    = '0;
    w_cand_ok = 1'b0;
    if (mode == MODE_SCAN) begin
      w_cand    = w_arb_idx;
      w_cand_ok = w_arb_found;
    end else begin
      w_cand    = sel;
      w_cand_ok = (int'(sel) < N_CH);
    end
  end

  assign w_load = !out_valid || out_ready;
  // rst_n gating keeps in_ready low while reset is asserted, even though the
  // register already reads empty.
  assign w_cap  = rst_n && w_load && w_cand_ok && in_valid[w_cand];

  always_comb begin
    in_ready = '0;
    if (w_cap) in_ready[w_cand] = 1'b1;
  end

  // Explicit wrap so a non-power-of-two channel count never reaches an
  // illegal index.
  assign w_ptr_nxt = (int'(w_cand) == N_CH-1) ? '0 : w_cand + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else if (w_cap) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ch_dat[w_cand];
      r_out_ch    <= w_cand;
      if (mode == MODE_SCAN) r_ptr <= w_ptr_nxt;
    end else if (w_load) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

`ifdef MUX_SCAN_PARITY_EN
  logic r_par;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_par <= 1'b0;
    else if (w_cap) r_par <= ^w_ch_dat[w_cand];
  end
  assign out_par = r_par;
`endif

endmodule

// File: tb/tb_mux_scan.sv
module tb_mux_scan;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [1:0]     sel;
  logic [W-1:0]   out_data;
  logic [1:0]     out_ch;
  logic           out_valid;
  logic           out_ready;
`ifdef MUX_SCAN_PARITY_EN
  logic           out_par;
`endif

  mux_scan #(.N_CH(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the output slot should hold, and where the
  // round-robin search resumes.
  bit       m_vld;
  bit [7:0] m_dat;
  int       m_ch;
  int       m_ptr;
  logic [N-1:0] obs_rdy;
  int       seq [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_vld = 0; m_dat = '0; m_ch = 0; m_ptr = 0;
  endtask

  // One clock: inputs were set just after a negedge. Checks in_ready
  // against the model, advances the model at the edge, checks outputs.
  task automatic tick();
    bit load;
    int cand;
    bit cap;
    logic [N-1:0] exp_rdy;
    #1;
    load = !m_vld || out_ready;
    cand = -1;
    if (mode == 1'b0) begin
      if (int'(sel) < N) cand = int'(sel);
    end else begin
      for (int k = 0; k < N; k++) begin
        if (cand < 0 && in_valid[(m_ptr + k) % N]) cand = (m_ptr + k) % N;
      end
    end
    cap = load && cand >= 0 && in_valid[cand];
    exp_rdy = '0;
    if (cap) exp_rdy[cand] = 1'b1;
    obs_rdy = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (cap) begin
      m_vld = 1;
      m_dat = in_data[cand*W +: W];
      m_ch  = cand;
      if (mode) m_ptr = (cand + 1) % N;
    end else if (load) begin
      m_vld = 0;
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    if (m_vld) begin
      chk("out_data", 32'(out_data), 32'(m_dat));
      chk("out_ch", 32'(out_ch), 32'(m_ch));
`ifdef MUX_SCAN_PARITY_EN
      chk("out_par", 32'(out_par), 32'(^m_dat));
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Manual select of channel 2.
    mode = 1'b0; sel = 2'd2; in_data = '0; in_data[2*W +: W] = 8'hA5;
    in_valid = 4'b0100; out_ready = 1'b1;
    tick();
    chk("man_rdy", 32'(obs_rdy), 32'h4);
    chk("man_dat", 32'(out_data), 32'hA5);
    chk("man_ch", 32'(out_ch), 32'd2);
    chk("man_vld", 32'(out_valid), 32'd1);

    // Backpressure: hold 3C while ch1 waits.
    sel = 2'd0; in_data[0*W +: W] = 8'h3C; in_valid = 4'b0001; out_ready = 1'b1;
    tick();
    chk("bp_load", 32'(out_data), 32'h3C);
    sel = 2'd1; in_data[1*W +: W] = 8'h5A; in_valid = 4'b0010; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rdy", 32'(obs_rdy), 32'h0);
      chk("bp_hold", 32'(out_data), 32'h3C);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_rel_rdy", 32'(obs_rdy), 32'h2);
    chk("bp_rel_dat", 32'(out_data), 32'h5A);
    chk("bp_rel_ch", 32'(out_ch), 32'd1);

    // Reset while the slot is full.
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    in_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(out_valid), 32'd0);
    chk("arst_dat", 32'(out_data), 32'd0);
    chk("arst_ch", 32'(out_ch), 32'd0);
    chk("arst_rdy", 32'(in_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Scan fairness with all channels valid.
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(8'h10 + i);
    for (int i = 0; i < 6; i++) begin
      tick();
      seq[i] = int'(out_ch);
    end
    chk("fair0", 32'(seq[0]), 32'd0);
    chk("fair1", 32'(seq[1]), 32'd1);
    chk("fair2", 32'(seq[2]), 32'd2);
    chk("fair3", 32'(seq[3]), 32'd3);
    chk("fair4", 32'(seq[4]), 32'd0);
    chk("fair5", 32'(seq[5]), 32'd1);

    // Move pointer to 3, then skip/wrap over channels 1 and 2.
    in_valid = 4'b0100;
    tick();
    chk("ptr3_ch", 32'(out_ch), 32'd2);
    in_valid = 4'b0110;
    tick(); chk("wrap_a", 32'(out_ch), 32'd1);
    tick(); chk("wrap_b", 32'(out_ch), 32'd2);
    tick(); chk("wrap_c", 32'(out_ch), 32'd1);

    // Single active channel is served every cycle.
    in_valid = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("single_ch", 32'(out_ch), 32'd3);
      chk("single_vld", 32'(out_valid), 32'd1);
    end

`ifdef MUX_SCAN_PARITY_EN
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
    in_data[0*W +: W] = 8'h07;
    tick(); chk("par_07", 32'(out_par), 32'd1);
    in_data[0*W +: W] = 8'h03;
    tick(); chk("par_03", 32'(out_par), 32'd0);
`endif

    // Randomised traffic with mode/sel changes and backpressure.
    for (int i = 0; i < 400; i++) begin
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom);
      in_data   = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
